// File: rtl/display_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : display_scan_ctrl
// Description : Four-digit multiplexed 7-segment scan controller. A prescaler
//               paces the digit slots, the first cycle of every slot is blanked
//               to avoid ghosting, and new values are double-buffered so they
//               only reach the display at a frame boundary.
// Options     : LEADING_ZERO_BLANK_EN - blank leading zero digits (digit 0
//               is always shown).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int PRESCALE = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        load,
  output logic        ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_start
);

  localparam logic [15:0] CNT_MAX = 16'(PRESCALE - 1);

  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] shown, shown_nxt;
  logic [15:0] pending, pending_nxt;
  logic        pend, pend_nxt;
  logic        ready_nxt;
  logic        tick, boundary, accept;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic [3:0]  digit;
  logic        lead_zero;

  // Hex digit to segments a..g (seg[6] = a).
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  // Scan timing and the pending/shown double buffer.
  always_comb begin
    tick        = (cnt == CNT_MAX);
    boundary    = tick && (idx == 2'd3);
    accept      = load && ready;
    cnt_nxt     = tick ? 16'd0 : cnt + 16'd1;
    idx_nxt     = tick ? idx + 2'd1 : idx;
    shown_nxt   = shown;
    pending_nxt = pending;
    pend_nxt    = pend;
    ready_nxt   = ready;
    if (boundary) begin
      // ready=1 implies nothing is pending, so a load landing on the
      // boundary can bypass the pending register entirely.
      if (accept) begin
        shown_nxt = data;
      end else if (pend) begin
        shown_nxt = pending;
        pend_nxt  = 1'b0;
        ready_nxt = 1'b1;
      end
    end else if (accept) begin
      pending_nxt = data;
      pend_nxt    = 1'b1;
      ready_nxt   = 1'b0;
    end
  end

  // Next-cycle display outputs, derived from the post-edge state.
  always_comb begin
    an_nxt  = 4'b0000;
    seg_nxt = 7'b0000000;
    case (idx_nxt)
      2'd0:    digit = shown_nxt[3:0];
      2'd1:    digit = shown_nxt[7:4];
      2'd2:    digit = shown_nxt[11:8];
      default: digit = shown_nxt[15:12];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_nxt)
      2'd0:    lead_zero = 1'b0;
      2'd1:    lead_zero = (shown_nxt[15:4] == 12'd0);
      2'd2:    lead_zero = (shown_nxt[15:8] == 8'd0);
      default: lead_zero = (shown_nxt[15:12] == 4'd0);
    endcase
`else
    lead_zero = 1'b0;
`endif
    // The first cycle of each slot stays dark so the previous digit's
    // segments never bleed into the next anode.
    if (cnt_nxt != 16'd0) begin
      an_nxt = 4'b0001 << idx_nxt;
      if (!lead_zero) begin
        seg_nxt = hex7(digit);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 16'd0;
      idx         <= 2'd0;
      shown       <= 16'd0;
      pending     <= 16'd0;
      pend        <= 1'b0;
      ready       <= 1'b1;
      an          <= 4'b0000;
      seg         <= 7'b0000000;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shown       <= shown_nxt;
      pending     <= pending_nxt;
      pend        <= pend_nxt;
      ready       <= ready_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      frame_start <= boundary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_display_scan_ctrl
// Description : Directed self-checking bench for display_scan_ctrl, PRESCALE=4
//               (16-cycle frame). Define LEADING_ZERO_BLANK_EN to check the
//               leading-zero blanking build.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic        load;
  logic        ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_start;

  int nvec = 0;
  int nerr = 0;
  int ncyc = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  // A zero digit in a leading position: blank when the option is on.
  localparam logic [6:0] SEG_LZ = LZB ? 7'b0000000 : SEG_0;

  display_scan_ctrl #(.PRESCALE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .load        (load),
    .ready       (ready),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic run_to(input int n);
    while (ncyc < n) step();
  endtask

  task automatic check_slot(input string tag, input int n,
                            input logic [3:0] an_exp, input logic [6:0] seg_exp);
    run_to(n);
    check({tag, "_an"},  {12'h000, an},  {12'h000, an_exp});
    check({tag, "_seg"}, {9'h000, seg},  {9'h000, seg_exp});
  endtask

  // Directed sequence; ncyc counts edges since the latest reset release.
  initial begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         slot;

    rst  = 1'b1;
    load = 1'b0;
    data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_an",    {12'h000, an},          16'h0000);
    check("rst_seg",   {9'h000, seg},          16'h0000);
    check("rst_ready", {15'h0000, ready},      16'h0001);
    check("rst_fs",    {15'h0000, frame_start}, 16'h0000);
    #3 rst = 1'b0;
    ncyc = 0;

    // First frame after release, no load: every slot lit with 0.
    for (int n = 1; n <= 16; n++) begin
      step();
      slot    = (n / 4) % 4;
      exp_an  = ((n % 4) != 0) ? (4'b0001 << slot) : 4'b0000;
      exp_seg = ((n % 4) == 0) ? 7'b0000000 : ((slot == 0) ? SEG_0 : SEG_LZ);
      check($sformatf("f0_an_%0d", n),  {12'h000, an},  {12'h000, exp_an});
      check($sformatf("f0_seg_%0d", n), {9'h000, seg},  {9'h000, exp_seg});
      check($sformatf("f0_fs_%0d", n),  {15'h0000, frame_start}, (n == 16) ? 16'h0001 : 16'h0000);
    end

    // Mid-frame load of 0x1234.
    run_to(18);
    data = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    check("ld1234_ready_drop", {15'h0000, ready}, 16'h0000);
    check_slot("ld1234_old_d3", 29, 4'b1000, SEG_LZ);
    run_to(31);
    check("ld1234_ready_wait", {15'h0000, ready}, 16'h0000);
    run_to(32);
    check("ld1234_ready_back", {15'h0000, ready}, 16'h0001);
    check("ld1234_fs",         {15'h0000, frame_start}, 16'h0001);
    check_slot("ld1234_d0", 33, 4'b0001, SEG_4);
    check_slot("ld1234_d1", 37, 4'b0010, SEG_3);
    check_slot("ld1234_d2", 41, 4'b0100, SEG_2);
    check_slot("ld1234_d3", 45, 4'b1000, SEG_1);

    // 0xAAAA accepted, then 0x5555 offered while busy.
    data = 16'hAAAA;
    load = 1'b1;
    step();
    check("ldAAAA_ready", {15'h0000, ready}, 16'h0000);
    data = 16'h5555;
    step();
    load = 1'b0;
    check("ld5555_ignored_ready", {15'h0000, ready}, 16'h0000);
    run_to(48);
    check("ldAAAA_ready_back", {15'h0000, ready}, 16'h0001);
    check_slot("ldAAAA_d0", 49, 4'b0001, SEG_A);
    check_slot("ldAAAA_d1", 53, 4'b0010, SEG_A);
    check_slot("ldAAAA_d2", 57, 4'b0100, SEG_A);
    check_slot("ldAAAA_d3", 61, 4'b1000, SEG_A);

    // Load of 0x00F0 exactly on the boundary edge.
    run_to(63);
    data = 16'h00F0;
    load = 1'b1;
    step();
    load = 1'b0;
    check("ld00F0_ready_bnd", {15'h0000, ready}, 16'h0001);
    check("ld00F0_fs",        {15'h0000, frame_start}, 16'h0001);
    check_slot("ld00F0_d0", 65, 4'b0001, SEG_0);
    check_slot("ld00F0_d1", 69, 4'b0010, SEG_F);
    check_slot("ld00F0_d2", 73, 4'b0100, SEG_LZ);
    check_slot("ld00F0_d3", 77, 4'b1000, SEG_LZ);
    check("ld00F0_ready_kept", {15'h0000, ready}, 16'h0001);

    // Reset between edges while a value is pending.
    run_to(82);
    data = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    check("pre_rst_ready", {15'h0000, ready}, 16'h0000);
    #2 rst = 1'b1;
    #1;
    check("arst_an",    {12'h000, an},           16'h0000);
    check("arst_seg",   {9'h000, seg},           16'h0000);
    check("arst_ready", {15'h0000, ready},       16'h0001);
    check("arst_fs",    {15'h0000, frame_start}, 16'h0000);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    ncyc = 0;
    check_slot("post_rst_d0", 1,  4'b0001, SEG_0);
    check_slot("post_rst_d3", 13, 4'b1000, SEG_LZ);
    run_to(16);
    check("post_rst_fs", {15'h0000, frame_start}, 16'h0001);
    check_slot("post_rst_f1_d0", 17, 4'b0001, SEG_0);
    check_slot("post_rst_f1_d3", 29, 4'b1000, SEG_LZ);
    check("post_rst_ready", {15'h0000, ready}, 16'h0001);

    // Leading-zero behaviour with shown = 0x0005.
    run_to(34);
    data = 16'h0005;
    load = 1'b1;
    step();
    load = 1'b0;
    check_slot("v0005_d0", 49, 4'b0001, SEG_5);
    check_slot("v0005_d1", 53, 4'b0010, SEG_LZ);
    check_slot("v0005_d2", 57, 4'b0100, SEG_LZ);
    check_slot("v0005_d3", 61, 4'b1000, SEG_LZ);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000, clock cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port data  input  16  four hex digits; digit k is data[4k+3:4k], and digit 0 is rightmost.
REQ-005 SHALL have port load  input  1  request to capture data; accepted only when ready=1.
REQ-006 SHALL have port ready  output  1  high when a new value can be accepted.
REQ-007 SHALL have port an  output  4  digit enables, active-high, one-hot or all-zero.
REQ-008 SHALL have port seg  output  7  segments a..g on seg[6]..seg[0], active-high.
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-010 SHALL keep a prescaler cnt counting 0..PRESCALE-1 and wrapping to 0; tick = (cnt==PRESCALE-1).
REQ-011 SHALL keep digit index idx 0..3, incrementing on tick and wrapping from 3 to 0.
REQ-012 SHALL set frame_start=1 in exactly the cycle after the edge where idx wraps 3->0, and 0 otherwise.
REQ-013 SHALL register an and seg; after each edge they are a function of the post-edge cnt, idx and shown register.
REQ-014 SHALL drive an=4'b0000 and seg=0 while cnt==0 (anti-ghost blank cycle); otherwise an[idx]=1 and other an bits 0.
REQ-015 SHALL drive seg from the hex decode of shown digit idx: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-016 SHALL, on load&&ready, capture data into a pending register, set pend=1 and drive ready=0 from the next cycle.
REQ-017 SHALL ignore load while ready=0; the pending value is not overwritten.
REQ-018 SHALL, at the frame boundary edge (tick with idx==3) with pend=1, copy pending to shown, clear pend and set ready=1.
REQ-019 SHALL, when load&&ready coincides with the frame boundary edge, write data directly to shown; ready stays 1.
REQ-020 SHALL never change shown except at a frame boundary, so a frame never mixes old and new digits.

Reset
REQ-021 SHALL, while rst=1, hold cnt=0, idx=0, shown=0, pending=0, pend=0, ready=1, an=0, seg=0 and frame_start=0, independent of clk.
REQ-022 SHALL, on reset mid-operation, discard any pending value; the first frame after release shows 0000.
REQ-023 SHALL start counting on the first rising clk edge after rst deasserts.

Configuration
REQ-024 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-025 SHALL, when LEADING_ZERO_BLANK_EN is defined, force seg=0 for every digit k>0 whose shown digits k..3 are all zero; digit 0 is always decoded, and an timing is unchanged.
REQ-026 SHALL, when LEADING_ZERO_BLANK_EN is undefined, decode all four digits, including leading zeros.

Verification
REQ-027 SHALL cover PRESCALE=4, reset release, no load: 16-cycle frame; an sequence per slot is 0000 then 0001x3, then 0000 then 0010x3, 0100, 1000; seg=1111110 when lit; frame_start pulses every 16 cycles.
REQ-028 SHALL cover load data=0x1234 mid-frame: ready=0 next cycle; at the next boundary ready=1; in the slot with an=0001, seg=0110011 (4), and in the slot with an=1000, seg=0110000 (1).
REQ-029 SHALL cover load 0xAAAA, then load 0x5555 while ready=0: next frame shows A (1110111) on all digits; 0x5555 never appears.
REQ-030 SHALL cover load 0x00F0 asserted exactly on the boundary edge: the following frame immediately shows F (1000111) on digit 1; ready never drops.
REQ-031 SHALL cover rst asserted mid-slot between edges: an=0, seg=0, ready=1 immediately; after release the frame shows 0000 with no previously pending value.
REQ-032 SHALL cover shown=0x0005: with LEADING_ZERO_BLANK_EN, digits 3..1 give seg=0 and digit 0 gives 1011011; without it, digits 3..1 give 1111110.
